// File: rtl/gnn_pkg.sv
// Shared GNN constants and the output-serializer state encoding.
// Used by both the GNN datapath and the result serializer.
package gnn_pkg;

    localparam int OUTPUT_SIZE = 21;
    localparam int NUM_WORDS   = 8;
    localparam int IDX_W       = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        SEND    = 2'd2
    } ser_state_t;

endpackage

// File: rtl/gnn_out_serializer.sv
// Collects the eight layer-2 result words as their ready flags arrive, then
// streams them out in index order (2*node + out) over a valid/ready handshake.
module gnn_out_serializer #(
    parameter int OUTPUT_SIZE = gnn_pkg::OUTPUT_SIZE,
    parameter int NUM_WORDS   = gnn_pkg::NUM_WORDS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [OUTPUT_SIZE-1:0] out0_node0,
    input  logic [OUTPUT_SIZE-1:0] out1_node0,
    input  logic [OUTPUT_SIZE-1:0] out0_node1,
    input  logic [OUTPUT_SIZE-1:0] out1_node1,
    input  logic [OUTPUT_SIZE-1:0] out0_node2,
    input  logic [OUTPUT_SIZE-1:0] out1_node2,
    input  logic [OUTPUT_SIZE-1:0] out0_node3,
    input  logic [OUTPUT_SIZE-1:0] out1_node3,
    input  logic                   out10_ready_node0,
    input  logic                   out11_ready_node0,
    input  logic                   out10_ready_node1,
    input  logic                   out11_ready_node1,
    input  logic                   out10_ready_node2,
    input  logic                   out11_ready_node2,
    input  logic                   out10_ready_node3,
    input  logic                   out11_ready_node3,
    output logic [OUTPUT_SIZE-1:0] dout,
    output logic                   dout_valid,
    input  logic                   dout_ready,
    output logic [2:0]             dout_idx,
    output logic                   dout_last,
    output logic                   busy,
    output logic                   overrun
);

    gnn_pkg::ser_state_t state, state_nxt;

    logic [NUM_WORDS-1:0]   rdy;
    logic [NUM_WORDS-1:0]   mask, mask_nxt;
    logic [NUM_WORDS-1:0]   cap;
    logic                   xfer;
    logic [OUTPUT_SIZE-1:0] word_in [NUM_WORDS];
    logic [OUTPUT_SIZE-1:0] hold    [NUM_WORDS];

    assign rdy = {out11_ready_node3, out10_ready_node3, out11_ready_node2, out10_ready_node2,
                  out11_ready_node1, out10_ready_node1, out11_ready_node0, out10_ready_node0};

    assign word_in[0] = out0_node0;
    assign word_in[1] = out1_node0;
    assign word_in[2] = out0_node1;
    assign word_in[3] = out1_node1;
    assign word_in[4] = out0_node2;
    assign word_in[5] = out1_node2;
    assign word_in[6] = out0_node3;
    assign word_in[7] = out1_node3;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        state_nxt = state;
        mask_nxt  = mask;
        cap       = '0;
        xfer      = 1'b0;
        unique case (state)
            gnn_pkg::IDLE, gnn_pkg::COLLECT: begin
                cap      = rdy & ~mask;
                mask_nxt = mask | cap;
                if (&mask_nxt)
                    state_nxt = gnn_pkg::SEND;
                else if (|mask_nxt)
                    state_nxt = gnn_pkg::COLLECT;
            end
            gnn_pkg::SEND: begin
                xfer = dout_valid & dout_ready;
                if (xfer && dout_idx == 3'd7) begin
                    state_nxt = gnn_pkg::IDLE;
                    mask_nxt  = '0;
                end
            end
            default: state_nxt = gnn_pkg::IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= gnn_pkg::IDLE;
            mask       <= '0;
            dout_valid <= 1'b0;
            dout_idx   <= '0;
            dout_last  <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
            // NOTE: the holding registers are reset on purpose so dout reads zero under reset.
            for (int i = 0; i < NUM_WORDS; i++)
                hold[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state <= state_nxt;
            mask  <= mask_nxt;
            busy  <= (state_nxt != gnn_pkg::IDLE);
            for (int i = 0; i < NUM_WORDS; i++)
                if (cap[i])
                    hold[i] <= word_in[i];

            if (state != gnn_pkg::SEND && state_nxt == gnn_pkg::SEND) begin
                dout_valid <= 1'b1;
                dout_idx   <= '0;
                dout_last  <= 1'b0;
            end else if (xfer) begin
                if (dout_idx == 3'd7) begin
                    dout_valid <= 1'b0;
                    dout_idx   <= '0;
                    dout_last  <= 1'b0;
                end else begin
                    dout_idx  <= dout_idx + 3'd1;
                    dout_last <= (dout_idx == 3'd6);
                end
            end

            // Flags arriving while streaming are dropped; remember that it happened.
            if (state == gnn_pkg::SEND && |rdy)
                overrun <= 1'b1;
        end
    end

    assign dout = dout_valid ? hold[dout_idx] : '0;

endmodule

// File: tb/tb_gnn_out_serializer.sv
// Directed bench for gnn_out_serializer: full-frame, staggered arrival,
// back-pressure, overrun, mid-frame reset and sign-bit pass-through.
module tb_gnn_out_serializer;

    localparam int W = 21;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] w [8];
    logic [7:0]   rdy;
    logic [W-1:0] dout;
    logic         dout_valid;
    logic         dout_ready;
    logic [2:0]   dout_idx;
    logic         dout_last;
    logic         busy;
    logic         overrun;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gnn_out_serializer dut (
        .clk              (clk),
        .rst              (rst),
        .out0_node0       (w[0]),
        .out1_node0       (w[1]),
        .out0_node1       (w[2]),
        .out1_node1       (w[3]),
        .out0_node2       (w[4]),
        .out1_node2       (w[5]),
        .out0_node3       (w[6]),
        .out1_node3       (w[7]),
        .out10_ready_node0(rdy[0]),
        .out11_ready_node0(rdy[1]),
        .out10_ready_node1(rdy[2]),
        .out11_ready_node1(rdy[3]),
        .out10_ready_node2(rdy[4]),
        .out11_ready_node2(rdy[5]),
        .out10_ready_node3(rdy[6]),
        .out11_ready_node3(rdy[7]),
        .dout             (dout),
        .dout_valid       (dout_valid),
        .dout_ready       (dout_ready),
        .dout_idx         (dout_idx),
        .dout_last        (dout_last),
        .busy             (busy),
        .overrun          (overrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Streams a captured frame with dout_ready held high, checking every word.
    task automatic expect_frame(input logic [W-1:0] exp [8], input string tag);
        for (int i = 0; i < 8; i++) begin
            check({tag, "_valid"}, 32'(dout_valid), 32'd1);
            check({tag, "_idx"},   32'(dout_idx),   32'(i));
            check({tag, "_dout"},  32'(dout),       32'(exp[i]));
            check({tag, "_last"},  32'(dout_last),  32'(i == 7));
            tick();
        end
        check({tag, "_end_valid"}, 32'(dout_valid), 32'd0);
        check({tag, "_end_busy"},  32'(busy),       32'd0);
        check({tag, "_end_last"},  32'(dout_last),  32'd0);
    endtask

    initial begin
        logic [W-1:0] exp [8];
        int           exp_idx;
        int           cyc;
        logic [2:0]   pat;

        rst        = 1'b1;
        rdy        = '0;
        dout_ready = 1'b0;
        for (int i = 0; i < 8; i++) w[i] = W'(i + 1);
        #12;
        check("rst_valid", 32'(dout_valid), 32'd0);
        check("rst_busy",  32'(busy),       32'd0);
        check("rst_idx",   32'(dout_idx),   32'd0);
        check("rst_dout",  32'(dout),       32'd0);
        check("rst_ovr",   32'(overrun),    32'd0);
        rst = 1'b0;

        // All eight flags together: words 1..8 on consecutive cycles.
        dout_ready = 1'b1;
        rdy        = 8'hFF;
        tick();
        rdy = '0;
        check("all_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 8; i++) exp[i] = W'(i + 1);
        expect_frame(exp, "all");

        // One flag per cycle, node3.out1 first; a repeat flag for word 7 is ignored.
        for (int i = 0; i < 8; i++) w[i] = W'(8'h10 + i);
        for (int k = 7; k >= 0; k--) begin
            rdy = 8'(1 << k) | ((k < 7) ? 8'h80 : 8'h00);
            if (k == 6) w[7] = 21'h1ABCD;
            tick();
            if (k > 0) begin
                check("stag_novalid", 32'(dout_valid), 32'd0);
                check("stag_busy",    32'(busy),       32'd1);
            end
        end
        rdy = '0;
        for (int i = 0; i < 8; i++) exp[i] = W'(8'h10 + i);
        expect_frame(exp, "stag");

        // Back-pressure 1,0,0 repeating: each word once, held during stalls.
        for (int i = 0; i < 8; i++) w[i] = W'(12'h100 + i);
        dout_ready = 1'b0;
        rdy        = 8'hFF;
        tick();
        rdy     = '0;
        pat     = 3'b001;
        exp_idx = 0;
        cyc     = 0;
        while (exp_idx < 8 && cyc < 40) begin
            dout_ready = pat[cyc % 3];
            check("stall_valid", 32'(dout_valid), 32'd1);
            check("stall_idx",   32'(dout_idx),   32'(exp_idx));
            check("stall_dout",  32'(dout),       32'(12'h100 + exp_idx));
            tick();
            if (dout_ready) exp_idx++;
            cyc++;
        end
        check("stall_count", 32'(exp_idx), 32'd8);
        check("stall_done",  32'(dout_valid), 32'd0);

        // Flag pulse during SEND is dropped and sets the sticky overrun.
        dout_ready = 1'b1;
        for (int i = 0; i < 8; i++) w[i] = W'(12'h200 + i);
        rdy = 8'hFF;
        tick();
        rdy = '0;
        for (int i = 0; i < 8; i++) begin
            check("ovr_idx",  32'(dout_idx), 32'(i));
            check("ovr_dout", 32'(dout),     32'(12'h200 + i));
            if (i == 2) begin
                w[3]   = 21'h1FFFFF;
                rdy[3] = 1'b1;
            end
            tick();
            rdy = '0;
        end
        check("ovr_flag",  32'(overrun),    32'd1);
        check("ovr_idle",  32'(dout_valid), 32'd0);
        tick();
        check("ovr_stick", 32'(overrun),    32'd1);

        // Asynchronous reset at dout_idx=3 abandons the frame.
        for (int i = 0; i < 8; i++) w[i] = W'(12'h300 + i);
        rdy = 8'hFF;
        tick();
        rdy = '0;
        tick();
        tick();
        tick();
        check("pre_rst_idx", 32'(dout_idx), 32'd3);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 32'(dout_valid), 32'd0);
        check("arst_idx",   32'(dout_idx),   32'd0);
        check("arst_dout",  32'(dout),       32'd0);
        check("arst_busy",  32'(busy),       32'd0);
        check("arst_ovr",   32'(overrun),    32'd0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        check("post_rst_valid", 32'(dout_valid), 32'd0);
        check("post_rst_busy",  32'(busy),       32'd0);

        // Fresh frame with sign-bit patterns passes through bit-exact.
        w[0] = 21'h100000; w[1] = 21'h1FFFFF; w[2] = 21'h000001; w[3] = 21'h0FFFFF;
        w[4] = 21'h155555; w[5] = 21'h0AAAAA; w[6] = 21'h100001; w[7] = 21'h1FFFFE;
        for (int i = 0; i < 8; i++) exp[i] = w[i];
        rdy = 8'hFF;
        tick();
        rdy = '0;
        expect_frame(exp, "neg");
        check("neg_ovr", 32'(overrun), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gnn_out_serializer.md
GNN_OUT_SERIALIZER -- requirements
Module: gnn_out_serializer

Interface
REQ-001 Parameter OUTPUT_SIZE, default 21, is the width of each layer-2 result word.
REQ-002 Parameter NUM_WORDS, default 8, is the number of result words per frame (4 nodes x 2 outputs).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 out{0,1}_node{0..3}  input  OUTPUT_SIZE each (8 ports)  layer-2 result words from the GNN datapath.
REQ-006 out1{0,1}_ready_node{0..3}  input  1 each (8 ports)  per-word ready flags; each port is paired with the same-named result word.
REQ-007 dout  output  OUTPUT_SIZE  serialized result word.
REQ-008 dout_valid  output  1  dout holds a valid word.
REQ-009 dout_ready  input  1  consumer accepts the word.
REQ-010 dout_idx  output  3  word index, = 2*node + out.
REQ-011 dout_last  output  1  high with word 7.
REQ-012 busy  output  1  high when state is not IDLE.
REQ-013 overrun  output  1  sticky flag: a ready flag was dropped.

Function
REQ-014 States SHALL be IDLE, COLLECT and SEND.
REQ-015 In IDLE or COLLECT, a word whose ready flag is sampled high and whose mask bit is clear SHALL be captured into its holding register, and its bit in an 8-bit capture mask SHALL be set.
REQ-016 A ready flag sampled high for an already-set mask bit SHALL be ignored, with data unchanged.
REQ-017 IDLE SHALL move to COLLECT when at least one word is captured and the mask is not then full.
REQ-018 Any state with the mask full after the edge SHALL move to SEND; this includes IDLE when all 8 flags are high together.
REQ-019 dout_valid SHALL rise on the clock edge that completes the mask, giving 1 cycle of latency from the final ready-flag edge; dout_idx SHALL be 0 at that point.
REQ-020 In SEND, dout SHALL present the word selected by dout_idx, in the order node0.out0, node0.out1, node1.out0, ... node3.out1.
REQ-021 A transfer SHALL occur when dout_valid and dout_ready are both high; dout_idx SHALL then increment on that edge.
REQ-022 dout, dout_idx and dout_last SHALL remain stable while dout_valid=1 and dout_ready=0.
REQ-023 The transfer at dout_idx=7 SHALL return the block to IDLE, clear the mask, and drop dout_valid and dout_last on that edge.
REQ-024 Any ready flag sampled high in SEND, including the final-transfer cycle, SHALL be dropped and SHALL set overrun.
REQ-025 overrun SHALL be cleared only by rst.
REQ-026 dout_ready SHALL be ignored outside SEND.
REQ-027 Data SHALL pass through unmodified with no sign or width change.

Reset
REQ-028 rst high SHALL immediately force the following, regardless of clk: state=IDLE, mask=0, dout_valid=0, dout_last=0, dout_idx=0, busy=0, overrun=0, dout=0, holding registers=0.
REQ-029 Reset asserted mid-SEND or mid-COLLECT SHALL abandon the frame; no partial word SHALL be emitted after release.
REQ-030 The first edge after rst deasserts SHALL sample the ready flags normally.

Structure
REQ-031 OUTPUT_SIZE, NUM_WORDS and the state encoding SHALL live in the shared package gnn_pkg, which the GNN datapath also uses.
REQ-032 The block SHALL be a single module with no sub-module; the word mux and mask SHALL be local logic.
REQ-033 Only dout_valid, dout_idx, dout_last, busy and overrun SHALL be driven from registers; dout SHALL be a mux of registered words.

Verification
REQ-034 All 8 flags high in one cycle with words 1..8 and dout_ready=1 SHALL give dout 1,2,...,8 on 8 consecutive cycles, dout_last with 8, and busy low afterwards.
REQ-035 Flags arriving one per cycle (node3.out1 first) with dout_ready=1 SHALL give dout_valid high only after the 8th flag, and words in index order, not arrival order.
REQ-036 dout_ready toggling 1,0,0,1,... SHALL give each word exactly once, with dout held stable during stall cycles.
REQ-037 A ready flag pulsed during SEND with value 0x1FFFFF SHALL set overrun=1 and leave the emitted frame unchanged.
REQ-038 rst asserted while dout_idx=3 SHALL clear all outputs asynchronously; a following full frame SHALL start at dout_idx=0.
REQ-039 Negative values 0x100000 and 0x1FFFFF SHALL be emitted bit-exact.
